calc1_port_master: RTL

Per-port request sequencer sitting directly upstream of `calc1`, one instance per calc1 port. It accepts whole operations (`cmd`, `op1`, `op2`) over a valid/ready interface and buffers them in a small FIFO. It serialises each operation onto calc1's two-cycle request protocol, then waits for calc1's response and returns result code plus data over a held valid/ready result interface. A watchdog covers responses that never arrive, and a saturating counter records stray responses.

---
 rtl/calc1_pkg.sv | 44 ++++
 rtl/calc1_req_fifo.sv | 71 +++++++
 rtl/calc1_port_master.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port master: bus widths, command and
// response encodings, the sequencer state type, the queued-operation record,
// and a small saturating-counter helper.
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    // calc1 command codes
    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    // calc1 response codes, plus the locally generated timeout code
    localparam logic [RESP_W-1:0] RESP_NONE    = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK      = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR     = 2'd2;
    localparam logic [RESP_W-1:0] RESP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND1,
        ST_SEND2,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // One queued operation: {cmd, op1, op2} = 68 bits
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } op_t;

    localparam int OP_W = $bits(op_t);

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/calc1_req_fifo.sv
// Request FIFO for the calc1 port master.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   wr_en, wr_data  - push request and entry (ignored when full and not popping)
//   rd_en, rd_data  - pop request and head entry (head is combinational from memory)
//   ready           - registered "not full"
//   empty           - registered "no entries"
//   empty_nxt       - emptiness after the current edge, for registered status elsewhere
// Pointers carry one extra MSB so full and empty are told apart without a counter.
module calc1_req_fifo
    import calc1_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             ready,
    output logic             empty,
    output logic             empty_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_wr;
    logic             do_rd;
    logic             full_nxt;

    assign do_rd = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (ready || do_rd);

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_wr};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_rd};

    assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    assign full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b1;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            ready  <= !full_nxt;
            empty  <= empty_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/calc1_port_master.sv
// Per-port request sequencer in front of one calc1 port.
// Accepts whole operations over op_valid/op_ready into a small FIFO, drives
// them onto calc1's two-cycle request bus (cmd+op1, then 0+op2), waits for
// the response with a watchdog, and presents the result as a held
// res_valid/res_ready transfer. Responses seen outside WAIT are counted.
// Ports:
//   c_clk, reset                     - clock, asynchronous active-high reset
//   op_valid/op_ready, op_cmd,
//   op_data1, op_data2               - upstream operation interface
//   req_cmd_out, req_data_out        - calc1 request bus
//   calc_resp, calc_data             - calc1 response bus
//   res_valid/res_ready, res_resp,
//   res_data                         - result interface (held until accepted)
//   busy                             - not idle or operations still queued
//   stray_cnt                        - saturating count of unexpected responses
// All outputs are registered.
module calc1_port_master
    import calc1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [CMD_W-1:0]  op_cmd,
    input  logic [DATA_W-1:0] op_data1,
    input  logic [DATA_W-1:0] op_data2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [RESP_W-1:0] calc_resp,
    input  logic [DATA_W-1:0] calc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RESP_W-1:0] res_resp,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic [7:0]        stray_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t state;
    state_t state_nxt;

    op_t    head;
    op_t    wr_op;
    logic   push;
    logic   pop;
    logic   fifo_empty;
    logic   fifo_empty_nxt;

    logic [DATA_W-1:0] op2_q;
    logic [DATA_W-1:0] op2_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;
    logic [CMD_W-1:0]  req_cmd_nxt;
    logic [DATA_W-1:0] req_data_nxt;
    logic              res_valid_nxt;
    logic [RESP_W-1:0] res_resp_nxt;
    logic [DATA_W-1:0] res_data_nxt;
    logic              busy_nxt;
    logic              stray;

    assign wr_op = '{cmd: op_cmd, op1: op_data1, op2: op_data2};
    assign push  = op_valid && op_ready;

    calc1_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk       (c_clk),
        .rst       (reset),
        .wr_en     (push),
        .wr_data   (wr_op),
        .rd_en     (pop),
        .rd_data   (head),
        .ready     (op_ready),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt)
    );

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of every registered output. The request bus
    // defaults to zero so it is only non-zero in SEND1/SEND2.
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        op2_nxt       = op2_q;
        timer_nxt     = timer;
        req_cmd_nxt   = '0;
        req_data_nxt  = '0;
        res_valid_nxt = res_valid;
        res_resp_nxt  = res_resp;
        res_data_nxt  = res_data;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.cmd == CMD_NOP) begin
                        // A no-op never reaches calc1; answer it locally.
                        state_nxt     = ST_HOLD;
                        res_valid_nxt = 1'b1;
                        res_resp_nxt  = RESP_ERR;
                        res_data_nxt  = '0;
                    end else begin
                        state_nxt    = ST_SEND1;
                        req_cmd_nxt  = head.cmd;
                        req_data_nxt = head.op1;
                        op2_nxt      = head.op2;
                    end
                end
            end
            ST_SEND1: begin
                state_nxt    = ST_SEND2;
                req_data_nxt = op2_q;
            end
            ST_SEND2: begin
                state_nxt = ST_WAIT;
                timer_nxt = '0;
            end
            ST_WAIT: begin
                // A response in the expiry cycle still wins over the timeout.
                if (calc_resp != RESP_NONE) begin
                    state_nxt     = ST_HOLD;
                    res_valid_nxt = 1'b1;
                    res_resp_nxt  = calc_resp;
                    res_data_nxt  = (calc_resp == RESP_OK) ? calc_data : '0;
                end else if (timer == TIMER_LAST) begin
                    state_nxt     = ST_HOLD;
                    res_valid_nxt = 1'b1;
                    res_resp_nxt  = RESP_TIMEOUT;
                    res_data_nxt  = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_nxt     = ST_IDLE;
                    res_valid_nxt = 1'b0;
                    res_resp_nxt  = RESP_NONE;
                    res_data_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE) || !fifo_empty_nxt;
    end

    assign stray = (calc_resp != RESP_NONE) && (state != ST_WAIT);

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            timer        <= '0;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            res_valid    <= 1'b0;
            res_resp     <= RESP_NONE;
            res_data     <= '0;
            busy         <= 1'b0;
            stray_cnt    <= '0;
        end else begin
            timer        <= timer_nxt;
            req_cmd_out  <= req_cmd_nxt;
            req_data_out <= req_data_nxt;
            res_valid    <= res_valid_nxt;
            res_resp     <= res_resp_nxt;
            res_data     <= res_data_nxt;
            busy         <= busy_nxt;
            if (stray) begin
                stray_cnt <= sat_inc8(stray_cnt);
            end
        end
    end

    // Second operand is pure data; it is always loaded before it is used.
    always_ff @(posedge c_clk) begin
        op2_q <= op2_nxt;
    end

endmodule
